reg_view_ctrl: RTL and testbench

- Sequencer for the CPU's debug register read port (regAddress/regData) and the 8-digit seven-segment display number input.
- Steps through register addresses x0..x31 on debounced key presses (manual mode) or on a dwell timer (auto-scan mode).
- Issues each read, waits out the read latency, captures regData and holds the value for display.
- Re-reads the selected register periodically so the display tracks live CPU state.

---
 rtl/reg_view_pkg.sv | 21 ++
 rtl/reg_view_ctrl_key_debounce.sv | 55 +++++
 rtl/reg_view_ctrl.sv | 146 ++++++++++++++
 tb/tb_reg_view_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_view_pkg.sv
// Shared types and defaults for the register-view sequencer.
// Optional build macro REG_VIEW_ADDR_OVERLAY_EN is consumed by reg_view_ctrl.
package reg_view_pkg;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_DWELL_CYCLES    = 50000000;
    localparam int DEF_REFRESH_CYCLES  = 1000000;

    // Bits needed to hold a counter running 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_view_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stable-level debouncer and a
// single-cycle pulse on each accepted press (debounced 1->0 transition).
module key_debounce
    import reg_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The accepted level only moves after the synchronized input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/reg_view_ctrl.sv
// Debug register viewer: steps x0..x31 by key or dwell timer, reads the CPU
// register port and holds the value for display. Macro: REG_VIEW_ADDR_OVERLAY_EN.
module reg_view_ctrl
    import reg_view_pkg::*;
#(
    parameter int ADDR_W          = 5,
    parameter int DATA_W          = 32,
    parameter int READ_LAT        = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES,
    parameter int REFRESH_CYCLES  = DEF_REFRESH_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_next_n,
    input  logic              key_prev_n,
    input  logic              auto_en,
    input  logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] disp_number,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int LAT_W   = cnt_width(READ_LAT + 1);
    localparam int DWELL_W = cnt_width(DWELL_CYCLES);
    localparam int REF_W   = cnt_width(REFRESH_CYCLES);

    logic next_p, prev_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_next_n),
        .press_o (next_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_prev_n),
        .press_o (prev_p)
    );

    state_e             state_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [ADDR_W-1:0]  reg_addr_q;
    logic [DATA_W-1:0]  disp_number_q;
    logic               disp_valid_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [REF_W-1:0]   refresh_q;
    logic               pend_next_q;
    logic               pend_prev_q;

    logic              step_fwd, step_back, dwell_hit, refresh_hit;
    logic [DATA_W-1:0] cap_data;

    always_comb begin
        step_fwd    = pend_next_q | next_p;
        step_back   = ~step_fwd & (pend_prev_q | prev_p);
        dwell_hit   = auto_en && (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
        refresh_hit = (refresh_q == REF_W'(REFRESH_CYCLES - 1));
    end

    // The index shown alongside the data is the address that was read.
    always_comb begin
        cap_data = reg_data;
`ifdef REG_VIEW_ADDR_OVERLAY_EN
        cap_data[DATA_W-1 -: 8] = 8'(reg_addr_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ISSUE;
            cur_addr_q    <= '0;
            reg_addr_q    <= '0;
            disp_number_q <= '0;
            disp_valid_q  <= 1'b0;
            lat_cnt_q     <= '0;
            dwell_q       <= '0;
            refresh_q     <= '0;
            pend_next_q   <= 1'b0;
            pend_prev_q   <= 1'b0;
        end else begin
            // Presses seen while a read is in flight are held one-deep, next over prev.
            if (state_q != HOLD) begin
                if (next_p) begin
                    pend_next_q <= 1'b1;
                    pend_prev_q <= 1'b0;
                end else if (prev_p && !pend_next_q) begin
                    pend_prev_q <= 1'b1;
                end
            end

            case (state_q)
                ISSUE: begin
                    reg_addr_q <= cur_addr_q;
                    lat_cnt_q  <= LAT_W'(READ_LAT);
                    state_q    <= (READ_LAT == 0) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (lat_cnt_q <= LAT_W'(1)) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    disp_number_q <= cap_data;
                    disp_valid_q  <= 1'b1;
                    dwell_q       <= '0;
                    refresh_q     <= '0;
                    state_q       <= HOLD;
                end
                HOLD: begin
                    pend_next_q <= 1'b0;
                    pend_prev_q <= 1'b0;
                    refresh_q   <= refresh_q + 1'b1;
                    if (auto_en) begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                    if (step_fwd) begin
                        cur_addr_q <= cur_addr_q + 1'b1;
                        state_q    <= ISSUE;
                    end else if (step_back) begin
                        cur_addr_q <= cur_addr_q - 1'b1;
                        state_q    <= ISSUE;
                    end else if (dwell_hit) begin
                        cur_addr_q <= cur_addr_q + 1'b1;
                        state_q    <= ISSUE;
                    end else if (refresh_hit) begin
                        state_q    <= ISSUE;
                    end
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    assign reg_addr    = reg_addr_q;
    assign disp_number = disp_number_q;
    assign disp_valid  = disp_valid_q;
    assign cur_addr    = cur_addr_q;

endmodule

// File: tb/tb_reg_view_ctrl.sv
// Directed bench for reg_view_ctrl with shortened debounce/dwell/refresh periods.
// Honours REG_VIEW_ADDR_OVERLAY_EN when computing expected display values.
module tb_reg_view_ctrl;

    localparam int READ_LAT = 1;
    localparam int DEB      = 20;
    localparam int DWELL    = 16;
    localparam int REFRESH  = 1000;

    logic        clk;
    logic        rst;
    logic        key_next_n;
    logic        key_prev_n;
    logic        auto_en;
    logic [31:0] reg_data;
    logic [4:0]  reg_addr;
    logic [31:0] disp_number;
    logic        disp_valid;
    logic [4:0]  cur_addr;

    logic [31:0] regfile [32];

    int checks = 0;
    int errors = 0;

    assign reg_data = regfile[reg_addr];

    reg_view_ctrl #(
        .ADDR_W          (5),
        .DATA_W          (32),
        .READ_LAT        (READ_LAT),
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL),
        .REFRESH_CYCLES  (REFRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_next_n  (key_next_n),
        .key_prev_n  (key_prev_n),
        .auto_en     (auto_en),
        .reg_data    (reg_data),
        .reg_addr    (reg_addr),
        .disp_number (disp_number),
        .disp_valid  (disp_valid),
        .cur_addr    (cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_disp(input logic [4:0] a, input logic [31:0] d);
`ifdef REG_VIEW_ADDR_OVERLAY_EN
        return {3'b000, a, d[23:0]};
`else
        return d;
`endif
    endfunction

    // Press one key, expect one step to exp_addr, a capture READ_LAT+2 cycles
    // after the step, and no repeat while the key stays down.
    task automatic press(input bit nxt, input logic [4:0] exp_addr, input string tag);
        logic [4:0] a0;
        a0 = cur_addr;
        if (nxt) key_next_n = 1'b0;
        else     key_prev_n = 1'b0;
        for (int n = 0; n < 200 && cur_addr === a0; n++) tick(1);
        check({tag, "_addr"}, 32'(cur_addr), 32'(exp_addr));
        tick(READ_LAT + 2);
        check({tag, "_disp"}, disp_number, exp_disp(exp_addr, regfile[exp_addr]));
        check({tag, "_raddr"}, 32'(reg_addr), 32'(exp_addr));
        tick(2 * DEB);
        check({tag, "_norepeat"}, 32'(cur_addr), 32'(exp_addr));
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        tick(2 * DEB);
        check({tag, "_release"}, 32'(cur_addr), 32'(exp_addr));
    endtask

    initial begin
        logic [4:0] a0;
        int         n;

        for (int i = 0; i < 32; i++) regfile[i] = 32'h01010101 * i;
        regfile[0]  = 32'h00000000;
        regfile[1]  = 32'hDEADBEEF;
        regfile[10] = 32'h12345678;
        regfile[31] = 32'h31313131;

        rst        = 1'b1;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        auto_en    = 1'b0;
        tick(3);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        check("rst_disp_number", disp_number, 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);

        // First read of x0: ISSUE, WAIT, CAPTURE.
        rst = 1'b0;
        tick(2);
        check("first_valid_early", 32'(disp_valid), 32'd0);
        tick(1);
        check("first_valid", 32'(disp_valid), 32'd1);
        check("first_disp", disp_number, 32'd0);
        check("first_raddr", 32'(reg_addr), 32'd0);

        // Manual stepping and wrap-around.
        press(1'b1, 5'd1, "next_1");
        press(1'b0, 5'd0, "prev_0");
        press(1'b0, 5'd31, "prev_wrap");
        press(1'b1, 5'd0, "next_wrap");

        // Bouncing key: level never stable long enough to be accepted.
        for (int i = 0; i < 40; i++) begin
            key_next_n = ~key_next_n;
            tick(5);
        end
        key_next_n = 1'b1;
        tick(2 * DEB);
        check("bounce_no_step", 32'(cur_addr), 32'd0);
        press(1'b1, 5'd1, "bounce_then_press");

        // Auto-scan: one step every DWELL + READ_LAT + 2 cycles.
        auto_en = 1'b1;
        a0 = cur_addr;
        for (n = 0; n < 100 && cur_addr === a0; n++) tick(1);
        check("auto_first", 32'(cur_addr), 32'd2);
        for (int k = 0; k < 3; k++) begin
            a0 = cur_addr;
            for (n = 0; n < 100 && cur_addr === a0; n++) tick(1);
            check("auto_period", 32'(n), 32'(DWELL + READ_LAT + 2));
            check("auto_addr", 32'(cur_addr), 32'(3 + k));
        end
        for (n = 0; n < 200 && cur_addr !== 5'd10; n++) tick(1);
        auto_en = 1'b0;
        check("auto_reach_10", 32'(cur_addr), 32'd10);
        tick(READ_LAT + 2);
`ifdef REG_VIEW_ADDR_OVERLAY_EN
        check("overlay_disp", disp_number, 32'h0A345678);
`else
        check("overlay_disp", disp_number, 32'h12345678);
`endif
        tick(40);
        check("auto_off_frozen", 32'(cur_addr), 32'd10);

        // Periodic refresh picks up a changed register value.
        regfile[10] = 32'hCAFEF00D;
        tick(500);
`ifdef REG_VIEW_ADDR_OVERLAY_EN
        check("refresh_old", disp_number, 32'h0A345678);
`else
        check("refresh_old", disp_number, 32'h12345678);
`endif
        tick(600);
`ifdef REG_VIEW_ADDR_OVERLAY_EN
        check("refresh_new", disp_number, 32'h0AFEF00D);
`else
        check("refresh_new", disp_number, 32'hCAFEF00D);
`endif
        check("refresh_addr", 32'(cur_addr), 32'd10);

        // Reset while a read is in flight.
        auto_en = 1'b1;
        a0 = cur_addr;
        for (n = 0; n < 100 && cur_addr === a0; n++) tick(1);
        check("midread_step", 32'(cur_addr), 32'd11);
        rst = 1'b1;
        tick(1);
        check("midread_cur_addr", 32'(cur_addr), 32'd0);
        check("midread_reg_addr", 32'(reg_addr), 32'd0);
        check("midread_disp", disp_number, 32'd0);
        check("midread_valid", 32'(disp_valid), 32'd0);
        rst     = 1'b0;
        auto_en = 1'b0;
        tick(3);
        check("post_rst_valid", 32'(disp_valid), 32'd1);
        check("post_rst_disp", disp_number, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
